// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus request/response types plus the arbiter's local state enum.
// Bus field encodings mirror the common cbus definitions used by the MMUs.
package cbus_arbiter_pkg;

    typedef logic [2:0]  msize_t;
    typedef logic [3:0]  mlen_t;
    typedef logic [1:0]  axi_burst_type_t;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    // len encodes (beats - 1)
    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN2  = 4'd1;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN16 = 4'd15;

    localparam axi_burst_type_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_type_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_type_t AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after last_grant,
// wrapping modulo N (safe for non-power-of-two N).
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    // One extra bit holds last_grant + k (at most 2N-1) before the wrap.
    logic [IDX_W:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        // Scan farthest-first so the nearest valid candidate is written last and wins.
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (valid[cand[IDX_W-1:0]]) begin
                winner    = cand[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin cbus arbiter: merges the MMU requesters onto one memory port,
// holding a registered grant from the first cycle until the last beat.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    arb_state_t             state, state_next;
    logic [IDX_W-1:0]       sel, sel_next;
    logic [IDX_W-1:0]       last_grant, last_grant_next;
    logic [NUM_INPUTS-1:0]  req_valid;
    logic [IDX_W-1:0]       winner;
    logic                   any_valid;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    rr_pick #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    // last_grant resets to the top index so input 0 wins the first round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            sel        <= '0;
            last_grant <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            // NOTE: non-blocking so all three registers see the same pre-edge values.
            state      <= state_next;
            sel        <= sel_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        sel_next        = sel;
        last_grant_next = last_grant;
        unique case (state)
            ARB_IDLE: begin
                if (any_valid) begin
                    sel_next   = winner;
                    state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A last beat outranks an abort; a dropped valid must not wedge the bus.
                if (oresp.ready && oresp.last) begin
                    last_grant_next = sel;
                    state_next      = ARB_IDLE;
                end else if (!ireqs[sel].valid) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        oreq = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            iresps[j] = '0;
        end
        if (state == ARB_BUSY) begin
            oreq        = ireqs[sel];
            iresps[sel] = oresp;
        end
    end

    assign busy      = (state == ARB_BUSY);
    assign grant_idx = sel;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized scoreboard bench for cbus_arbiter against a transaction-level
// round-robin model with simple requester and memory agents.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [0:0] grant_idx;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    typedef struct {
        int          port;
        logic [63:0] addr;
        logic [3:0]  len;
        logic        is_write;
        logic        ready;
        logic        last;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic busy;
        int   grant;
    } status_t;

    beat_t   beat_q[$];
    status_t stat_q[$];
    int      errors = 0;
    int      checks = 0;
    bit      mon_en = 1'b0;

    // Requester agents
    bit          act    [N];
    logic [63:0] r_addr [N];
    logic [63:0] r_data [N];
    int          r_len  [N];
    int          r_done [N];
    bit          r_wr   [N];

    // Stimulus knobs
    int p_start [N];
    int p_abort;
    int p_ready;
    int force_len;

    // Reference model: -1 means nobody owns the bus
    int owner;
    int sel_m;
    int lg;

    task automatic check(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        sel_m = 0;
        lg    = N - 1;
        for (int i = 0; i < N; i++) begin
            act[i]   = 1'b0;
            ireqs[i] = '0;
        end
        oresp = '0;
    endtask

    task automatic cycle();
        logic        rdy, lst;
        logic [63:0] dat;
        int          lens[3];
        lens = '{0, 1, 3};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!act[i]) begin
                if (int'($urandom_range(99)) < p_start[i]) begin
                    act[i]    = 1'b1;
                    r_addr[i] = {32'h0, 32'h8000_0000 | ($urandom & 32'h0fff_fff8)};
                    r_data[i] = {$urandom, $urandom};
                    r_len[i]  = (force_len >= 0) ? force_len : lens[$urandom_range(2)];
                    r_done[i] = 0;
                    r_wr[i]   = 1'($urandom_range(1));
                end
            end else if (r_done[i] == 0 && int'($urandom_range(99)) < p_abort) begin
                act[i] = 1'b0;
            end
            ireqs[i]          = '0;
            ireqs[i].valid    = act[i];
            ireqs[i].is_write = r_wr[i];
            ireqs[i].size     = MSIZE8;
            ireqs[i].addr     = r_addr[i];
            ireqs[i].strobe   = r_wr[i] ? 8'hff : 8'h00;
            ireqs[i].data     = r_data[i];
            ireqs[i].len      = 4'(r_len[i]);
            ireqs[i].burst    = AXI_BURST_INCR;
        end

        rdy = 1'b0;
        lst = 1'b0;
        dat = {$urandom, $urandom};
        if (owner >= 0 && act[owner]) begin
            rdy = (int'($urandom_range(99)) < p_ready);
            lst = rdy && (r_done[owner] == r_len[owner]);
        end
        oresp.ready = rdy;
        oresp.last  = lst;
        oresp.data  = dat;

        stat_q.push_back('{owner >= 0, sel_m});
        if (owner >= 0 && act[owner]) begin
            beat_q.push_back('{owner, r_addr[owner], 4'(r_len[owner]), r_wr[owner], rdy, lst, dat});
        end
        mon_en = 1'b1;

        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (lg + k) % N;
                if (act[c]) begin
                    owner = c;
                    sel_m = c;
                    break;
                end
            end
        end else if (rdy && lst) begin
            lg         = owner;
            act[owner] = 1'b0;
            owner      = -1;
        end else begin
            if (rdy) r_done[owner]++;
            if (!act[owner]) owner = -1;
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic set_knobs(input int s0, input int s1, input int ab, input int rd, input int fl);
        p_start[0] = s0;
        p_start[1] = s1;
        p_abort    = ab;
        p_ready    = rd;
        force_len  = fl;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stat_q.size() == 0) begin
                check("status_underflow", 128'(stat_q.size()), 128'(1));
            end else begin
                status_t s;
                s = stat_q.pop_front();
                check("busy", 128'(busy), 128'(s.busy));
                check("grant_idx", 128'(grant_idx), 128'(s.grant));
            end
            if (oreq.valid) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_oreq_valid", 128'(oreq.valid), 128'(0));
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check("beat_grant", 128'(grant_idx), 128'(e.port));
                    check("oreq_addr", 128'(oreq.addr), 128'(e.addr));
                    check("oreq_len", 128'(oreq.len), 128'(e.len));
                    check("oreq_is_write", 128'(oreq.is_write), 128'(e.is_write));
                    for (int j = 0; j < N; j++) begin
                        if (j == e.port) begin
                            check("grant_ready", 128'(iresps[j].ready), 128'(e.ready));
                            if (e.ready) begin
                                check("grant_last", 128'(iresps[j].last), 128'(e.last));
                                check("grant_data", 128'(iresps[j].data), 128'(e.data));
                            end
                        end else begin
                            check("other_port_zero", 128'(iresps[j]), 128'(0));
                        end
                    end
                end
            end else begin
                for (int j = 0; j < N; j++) begin
                    check("no_ready_without_req", 128'(iresps[j].ready), 128'(0));
                end
            end
        end
    end

    initial begin
        bit reached;
        model_reset();
        set_knobs(0, 0, 0, 100, -1);

        // Reset holds outputs quiet even with requests pending.
        reset = 1'b0;
        ireqs[0].valid = 1'b1;
        ireqs[1].valid = 1'b1;
        #3;
        check("rst_oreq_valid", 128'(oreq.valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant_idx", 128'(grant_idx), 128'(0));
        check("rst_iresp0", 128'(iresps[0]), 128'(0));
        check("rst_iresp1", 128'(iresps[1]), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_busy", 128'(busy), 128'(0));
        model_reset();
        reset = 1'b1;

        set_knobs(100, 0, 0, 50, 0);     // single requester, MLEN1
        run(40);
        set_knobs(100, 100, 0, 100, 0);  // contention, single beats
        run(30);
        set_knobs(100, 100, 0, 70, 3);   // bursts of 4 under contention
        run(60);
        set_knobs(100, 100, 30, 30, -1); // aborts before first beat
        run(100);

        // Asynchronous reset while input 1 holds the grant.
        set_knobs(0, 100, 0, 0, 0);
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            cycle();
            reached = (owner == 1);
        end
        check("reached_grant1", 128'(reached), 128'(1));
        cycle();
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_oreq_valid", 128'(oreq.valid), 128'(0));
        check("async_rst_iresp0", 128'(iresps[0]), 128'(0));
        check("async_rst_iresp1", 128'(iresps[1]), 128'(0));
        check("async_rst_busy", 128'(busy), 128'(0));
        check("async_rst_grant", 128'(grant_idx), 128'(0));
        beat_q.delete();
        stat_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_knobs(100, 100, 0, 100, 0);  // first grant after reset goes to 0
        run(10);

        for (int r = 0; r < 20; r++) begin
            set_knobs(int'($urandom_range(100)), int'($urandom_range(100)),
                      int'($urandom_range(10)), int'($urandom_range(100, 20)), -1);
            run(100);
        end

        set_knobs(0, 0, 0, 100, -1);
        run(40);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("beat_q_drained", 128'(beat_q.size()), 128'(0));
        check("stat_q_drained", 128'(stat_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
